regfile_wb_scheduler: RTL

Write-back scheduler for the integer register file. It arbitrates the file's single write port between the execute stage (ALU results) and the load unit (memory returns), with round-robin fairness. It keeps a per-register busy scoreboard for outstanding loads and supplies hazard and forwarding information to decode. It sits between execute/load-store and the register file's write port.

---
 rtl/regfile_wb_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/regfile_wb_scheduler.sv
// Round-robin write-back arbiter (execute vs load return) with load busy scoreboard, hazard and forwarding.
// Latency: grant in cycle N drives wr_en/wr_addr/wr_data in N+1; a losing requester stalls until granted.
module regfile_wb_scheduler #(
    parameter int addr_w = 5,
    parameter int data_w = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid,
    input  logic [addr_w-1:0]        ex_addr,
    input  logic [data_w-1:0]        ex_data,
    output logic                     ex_ready,
    input  logic                     ld_valid,
    input  logic [addr_w-1:0]        ld_addr,
    input  logic [data_w-1:0]        ld_data,
    output logic                     ld_ready,
    input  logic                     ld_issue,
    input  logic [addr_w-1:0]        ld_issue_addr,
    input  logic [addr_w-1:0]        rs1_addr,
    input  logic [addr_w-1:0]        rs2_addr,
    input  logic [addr_w-1:0]        rd_addr,
    output logic                     hazard,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [data_w-1:0]        fwd_data,
    output logic                     wr_en,
    output logic [addr_w-1:0]        wr_addr,
    output logic [data_w-1:0]        wr_data,
    output logic [(1<<addr_w)-1:0]   busy,
    output logic                     sb_err
);
    localparam int nreg = 1 << addr_w;

    typedef struct packed {
        logic [addr_w-1:0] addr;
        logic [data_w-1:0] data;
    } wb_t;

    logic            pri_ld;
    logic            ex_elig;
    logic            ld_elig;
    logic            grant_ex;
    logic            grant_ld;
    wb_t             win;
    logic [nreg-1:0] busy_set;
    logic [nreg-1:0] busy_clr;
    logic            issue_err;
    logic            ret_err;

    // An execute write to a register with a load outstanding must wait so the older load cannot overwrite it.
    always_comb begin
        ex_elig  = ex_valid && ((ex_addr == '0) || !busy[ex_addr]);
        ld_elig  = ld_valid;
        grant_ld = ld_elig && (!ex_elig || pri_ld);
        grant_ex = ex_elig && (!ld_elig || !pri_ld);
    end

    assign ex_ready = rst_n & grant_ex;
    assign ld_ready = rst_n & grant_ld;

    always_comb begin
        win = grant_ld ? wb_t'{addr: ld_addr, data: ld_data}
                       : wb_t'{addr: ex_addr, data: ex_data};
    end

    // Set is applied after clear so a re-issue on the returning edge keeps the register busy.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (ld_issue && (ld_issue_addr != '0))
            busy_set[ld_issue_addr] = 1'b1;
        if (grant_ld && (ld_addr != '0))
            busy_clr[ld_addr] = 1'b1;
        issue_err = ld_issue && (ld_issue_addr != '0) && busy[ld_issue_addr];
        ret_err   = grant_ld && !busy[ld_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= (busy & ~busy_clr) | busy_set;
            if (issue_err || ret_err)
                sb_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            pri_ld  <= 1'b1;
        end else if (grant_ld || grant_ex) begin
            wr_en   <= (win.addr != '0);
            wr_addr <= win.addr;
            wr_data <= win.data;
            pri_ld  <= grant_ex;
        end else begin
            wr_en <= 1'b0;
        end
    end

    always_comb begin
        hazard = (busy[rs1_addr] && (rs1_addr != '0)) ||
                 (busy[rs2_addr] && (rs2_addr != '0)) ||
                 (busy[rd_addr]  && (rd_addr  != '0));
    end

    assign fwd1_hit = wr_en && (wr_addr == rs1_addr) && (rs1_addr != '0);
    assign fwd2_hit = wr_en && (wr_addr == rs2_addr) && (rs2_addr != '0);
    assign fwd_data = wr_data;

endmodule
